// File: rtl/shift_pkg.sv
// Shared types and defaults for the right-shift frame receiver.
package shift_pkg;

  // Receiver state: waiting for a SYNC-marked bit, or assembling a frame.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } rx_state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/rx_hold_buffer.sv
// One-entry valid/ready holding register for completed words.
// A word that arrives while the entry is full and not being drained is
// dropped and flagged in the sticky overrun bit.
module rx_hold_buffer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             dvld,
  output logic             ovr
);

  logic [WIDTH-1:0] dout_q;
  logic             dvld_q;
  logic             ovr_q;

  // Load, drain or drop; a drain on the load edge frees the slot for the new word.
  always_ff @(posedge clk) begin
    if (clear) begin
      dout_q <= '0;
      dvld_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (load) begin
      if (!dvld_q || rdy) begin
        dout_q <= word;
        dvld_q <= 1'b1;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (dvld_q && rdy) begin
      dvld_q <= 1'b0;
    end
  end

  assign dout = dout_q;
  assign dvld = dvld_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/shift_deserializer_right.sv
// Serial-in/parallel-out frame receiver. Bits arrive LSB-first and enter at
// the MSB of the shift register, so after WIDTH bits the first bit sits at
// bit 0. Completed words go to a one-entry valid/ready holding buffer.
module shift_deserializer_right
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             SIN,
  input  logic             SVLD,
  input  logic             SYNC,
  input  logic             DRDY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVLD,
  output logic             BUSY,
  output logic             OVR,
  output logic             FERR
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ferr_q, ferr_d;
  logic             word_done;
  logic [WIDTH-1:0] shifted;

  assign shifted = {SIN, sr_q[WIDTH-1:1]};

  // Next-state, shift and count logic; defaults hold everything.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ferr_d    = ferr_q;
    word_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (SVLD && SYNC) begin
          sr_d    = shifted;
          cnt_d   = CW'(1);
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (SVLD) begin
          sr_d = shifted;
          if (SYNC) begin
            // Restart: this bit is bit 0 of a new frame.
            ferr_d = 1'b1;
            cnt_d  = CW'(1);
          end else if (cnt_q == LAST_CNT) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  rx_hold_buffer #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk  (CLK),
    .clear(Clear),
    .load (word_done),
    .word (shifted),
    .rdy  (DRDY),
    .dout (DOUT),
    .dvld (DVLD),
    .ovr  (OVR)
  );

  assign BUSY = (state_q == S_RECV);
  assign FERR = ferr_q;

endmodule

// File: tb/tb_shift_deserializer_right.sv
// Directed bench for shift_deserializer_right at WIDTH=4.
module tb_shift_deserializer_right;

  logic       CLK = 1'b0;
  logic       Clear = 1'b1;
  logic       SIN = 1'b0;
  logic       SVLD = 1'b0;
  logic       SYNC = 1'b0;
  logic       DRDY = 1'b0;
  logic [3:0] DOUT;
  logic       DVLD;
  logic       BUSY;
  logic       OVR;
  logic       FERR;

  int tests = 0;
  int fails = 0;

  shift_deserializer_right #(
    .WIDTH(4)
  ) dut (
    .CLK  (CLK),
    .Clear(Clear),
    .SIN  (SIN),
    .SVLD (SVLD),
    .SYNC (SYNC),
    .DRDY (DRDY),
    .DOUT (DOUT),
    .DVLD (DVLD),
    .BUSY (BUSY),
    .OVR  (OVR),
    .FERR (FERR)
  );

  always #5 CLK = ~CLK;

  // One valid bit through one edge; outputs are sampled 1ns after the edge.
  task automatic send_bit(input logic b, input logic s, input logic r);
    SIN = b; SVLD = 1'b1; SYNC = s; DRDY = r;
    @(posedge CLK); #1;
    SVLD = 1'b0; SYNC = 1'b0; SIN = 1'b0;
  endtask

  task automatic idle(input int n, input logic r);
    SVLD = 1'b0; SYNC = 1'b0; DRDY = r;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    idle(2, 1'b0);
    Clear = 1'b0;
    tests++;
    if ({DOUT, DVLD, BUSY, OVR, FERR} !== 8'h00) begin
      fails++;
      $display("FAIL reset: got DOUT=%h DVLD=%b BUSY=%b OVR=%b FERR=%b, want all 0",
               DOUT, DVLD, BUSY, OVR, FERR);
    end
  endtask

  task automatic test_basic();
    send_bit(1'b1, 1'b1, 1'b1);
    tests++;
    if (BUSY !== 1'b1) begin fails++; $display("FAIL basic_busy1: got %b want 1", BUSY); end
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    tests++;
    if (BUSY !== 1'b1 || DVLD !== 1'b0) begin
      fails++; $display("FAIL basic_mid: got BUSY=%b DVLD=%b want 1 0", BUSY, DVLD);
    end
    send_bit(1'b1, 1'b0, 1'b1);
    tests++;
    if (DOUT !== 4'hD || DVLD !== 1'b1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL basic_word: got DOUT=%h DVLD=%b BUSY=%b want d 1 0", DOUT, DVLD, BUSY);
    end
    idle(1, 1'b1);
    tests++;
    if (DVLD !== 1'b0 || DOUT !== 4'hD) begin
      fails++; $display("FAIL basic_drain: got DVLD=%b DOUT=%h want 0 d", DVLD, DOUT);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] w;
    w = 4'h6;
    for (int i = 0; i < 4; i++) begin
      send_bit(w[i], (i == 0), 1'b1);
      if (i < 3) begin
        idle(3, 1'b1);
        tests++;
        if (BUSY !== 1'b1 || DVLD !== 1'b0) begin
          fails++;
          $display("FAIL gaps_hold%0d: got BUSY=%b DVLD=%b want 1 0", i, BUSY, DVLD);
        end
      end
    end
    tests++;
    if (DOUT !== 4'h6 || DVLD !== 1'b1 || OVR !== 1'b0 || FERR !== 1'b0) begin
      fails++;
      $display("FAIL gaps_word: got DOUT=%h DVLD=%b OVR=%b FERR=%b want 6 1 0 0",
               DOUT, DVLD, OVR, FERR);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_overrun();
    logic [3:0] a, b, c;
    a = 4'hA; b = 4'h3; c = 4'h5;
    for (int i = 0; i < 4; i++) send_bit(a[i], (i == 0), 1'b0);
    tests++;
    if (DOUT !== 4'hA || DVLD !== 1'b1) begin
      fails++; $display("FAIL ovr_first: got DOUT=%h DVLD=%b want a 1", DOUT, DVLD);
    end
    for (int i = 0; i < 4; i++) send_bit(b[i], (i == 0), 1'b0);
    tests++;
    if (DOUT !== 4'hA || DVLD !== 1'b1 || OVR !== 1'b1) begin
      fails++;
      $display("FAIL ovr_drop: got DOUT=%h DVLD=%b OVR=%b want a 1 1", DOUT, DVLD, OVR);
    end
    idle(1, 1'b1);
    tests++;
    if (DVLD !== 1'b0) begin fails++; $display("FAIL ovr_drain: got DVLD=%b want 0", DVLD); end
    for (int i = 0; i < 4; i++) send_bit(c[i], (i == 0), 1'b1);
    tests++;
    if (DOUT !== 4'h5 || DVLD !== 1'b1 || OVR !== 1'b1) begin
      fails++;
      $display("FAIL ovr_next: got DOUT=%h DVLD=%b OVR=%b want 5 1 1", DOUT, DVLD, OVR);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_frame_error();
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    tests++;
    if (FERR !== 1'b0) begin fails++; $display("FAIL ferr_early: got %b want 0", FERR); end
    send_bit(1'b1, 1'b1, 1'b1);
    tests++;
    if (FERR !== 1'b1 || BUSY !== 1'b1) begin
      fails++; $display("FAIL ferr_abort: got FERR=%b BUSY=%b want 1 1", FERR, BUSY);
    end
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    tests++;
    if (DOUT !== 4'h7 || DVLD !== 1'b1 || FERR !== 1'b1) begin
      fails++;
      $display("FAIL ferr_word: got DOUT=%h DVLD=%b FERR=%b want 7 1 1", DOUT, DVLD, FERR);
    end
  endtask

  task automatic test_clear_midframe();
    logic [3:0] w;
    w = 4'h9;
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    Clear = 1'b1;
    idle(1, 1'b0);
    Clear = 1'b0;
    tests++;
    if ({DOUT, DVLD, BUSY, OVR, FERR} !== 8'h00) begin
      fails++;
      $display("FAIL clr_mid: got DOUT=%h DVLD=%b BUSY=%b OVR=%b FERR=%b want all 0",
               DOUT, DVLD, BUSY, OVR, FERR);
    end
    send_bit(1'b1, 1'b0, 1'b1);
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL clr_nosync: got BUSY=%b want 0", BUSY); end
    for (int i = 0; i < 4; i++) send_bit(w[i], (i == 0), 1'b1);
    tests++;
    if (DOUT !== 4'h9 || DVLD !== 1'b1 || FERR !== 1'b0) begin
      fails++;
      $display("FAIL clr_word: got DOUT=%h DVLD=%b FERR=%b want 9 1 0", DOUT, DVLD, FERR);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b;
    a = 4'hC; b = 4'h5;
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(a[i], (i == 0), 1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i], (i == 0), 1'b0);
    tests++;
    if (DOUT !== 4'hC || DVLD !== 1'b1) begin
      fails++; $display("FAIL b2b_stable: got DOUT=%h DVLD=%b want c 1", DOUT, DVLD);
    end
    send_bit(b[3], 1'b0, 1'b1);
    tests++;
    if (DOUT !== 4'h5 || DVLD !== 1'b1 || OVR !== 1'b0) begin
      fails++;
      $display("FAIL b2b_word: got DOUT=%h DVLD=%b OVR=%b want 5 1 0", DOUT, DVLD, OVR);
    end
    idle(1, 1'b1);
    tests++;
    if (DVLD !== 1'b0) begin fails++; $display("FAIL b2b_drain: got DVLD=%b want 0", DVLD); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_frame_error();
    test_clear_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
